// File: rtl/instr_pkg.sv
// Shared instruction-set definitions: opcode map, encoded field positions and
// the operand-packing format of each opcode. Also used by the CPU control unit.
package instr_pkg;

  localparam int INSTR_W = 32;
  localparam int FIELD_W = 8;
  localparam int OPC_LSB = 24;
  localparam int F2_LSB  = 16;
  localparam int F1_LSB  = 8;
  localparam int F0_LSB  = 0;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;
  localparam logic [7:0] OP_J     = 8'h06;
  localparam logic [7:0] OP_BEQ   = 8'h07;
  localparam logic [7:0] OP_BNE   = 8'h08;
  localparam logic [7:0] OP_SRL   = 8'h09;
  localparam logic [7:0] OP_SLL   = 8'h0A;
  localparam logic [7:0] OP_ROR   = 8'h0B;
  localparam logic [7:0] OP_SRA   = 8'h0C;
  localparam logic [7:0] OP_MUL   = 8'h0D;
  // First opcode value that is not part of the instruction set.
  localparam logic [7:0] OP_ILLEGAL_MIN = 8'h0E;

  typedef struct packed {
    logic [7:0] opcode;
    logic [2:0] rd;
    logic [2:0] rt;
    logic [2:0] rs;
    logic [7:0] imm;
  } op_req_t;

  typedef enum logic [2:0] {
    FMT_RRR, FMT_MOV, FMT_LDI, FMT_SHI, FMT_BR, FMT_J, FMT_BAD
  } fmt_e;

  function automatic logic op_legal(input logic [7:0] op);
    return op < OP_ILLEGAL_MIN;
  endfunction

  function automatic fmt_e op_format(input logic [7:0] op);
    fmt_e f;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MUL: f = FMT_RRR;
      OP_MOV:                                f = FMT_MOV;
      OP_LOADI:                              f = FMT_LDI;
      OP_SRL, OP_SLL, OP_ROR, OP_SRA:        f = FMT_SHI;
      OP_BEQ, OP_BNE:                        f = FMT_BR;
      OP_J:                                  f = FMT_J;
      default:                               f = FMT_BAD;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Producer/consumer bus of the instruction encoder.
interface instr_encoder_if #(parameter int DEPTH = 4);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_opcode;
  logic [2:0]    in_rd;
  logic [2:0]    in_rt;
  logic [2:0]    in_rs;
  logic [7:0]    in_imm;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instruction;
  logic          illegal;
  logic [7:0]    illegal_count;
  logic [CW-1:0] count;

  modport slave (
    input  in_valid, in_opcode, in_rd, in_rt, in_rs, in_imm, out_ready,
    output in_ready, out_valid, out_instruction, illegal, illegal_count, count
  );

  modport master (
    output in_valid, in_opcode, in_rd, in_rt, in_rs, in_imm, out_ready,
    input  in_ready, out_valid, out_instruction, illegal, illegal_count, count
  );
endinterface

// File: rtl/instr_fifo.sv
// Synchronous FIFO of encoded words; head reads as zero while empty.
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [W-1:0]  i_data,
  output logic [W-1:0]  o_data,
  output logic [CW-1:0] o_count
);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic          w_push, w_pop;

  assign w_push  = i_push & (r_count != FULL_C);
  assign w_pop   = i_pop & (r_count != '0);
  assign o_count = r_count;
  assign o_data  = (r_count == '0) ? '0 : r_mem[r_rptr];

  // Power-of-two depth: pointers wrap naturally.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end
endmodule

// File: rtl/instr_encoder.sv
// Packs decoded operations into 32-bit instruction words and queues them;
// unknown opcodes are handshaken, dropped, flagged and counted.
module instr_encoder
  import instr_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic           i_clk,
  input  logic           i_reset,
  instr_encoder_if.slave io_bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  op_req_t          w_req;
  fmt_e             w_fmt;
  logic [7:0]       w_rd8, w_rt8, w_rs8;
  logic [7:0]       w_f2, w_f1, w_f0;
  logic [31:0]      w_word;
  logic             w_legal, w_in_ready, w_accept, w_pop;
  logic [CW-1:0]    w_count;
  logic [INSTR_W-1:0] w_head;
  logic             r_illegal;
  logic [7:0]       r_illegal_cnt;

  assign w_req = '{opcode: io_bus.in_opcode, rd: io_bus.in_rd, rt: io_bus.in_rt,
                   rs: io_bus.in_rs, imm: io_bus.in_imm};
  assign w_fmt   = op_format(w_req.opcode);
  assign w_legal = op_legal(w_req.opcode);
  assign w_rd8   = {5'b0, w_req.rd};
  assign w_rt8   = {5'b0, w_req.rt};
  assign w_rs8   = {5'b0, w_req.rs};

  always_comb begin
    w_f2 = '0;
    w_f1 = '0;
    w_f0 = '0;
    case (w_fmt)
      FMT_RRR: begin w_f2 = w_rd8;       w_f1 = w_rt8; w_f0 = w_rs8;       end
      FMT_MOV: begin w_f2 = w_rd8;                     w_f0 = w_rs8;       end
      FMT_LDI: begin w_f2 = w_rd8;                     w_f0 = w_req.imm;   end
      FMT_SHI: begin w_f2 = w_rd8;       w_f1 = w_rt8; w_f0 = w_req.imm;   end
      FMT_BR:  begin w_f2 = w_req.imm;   w_f1 = w_rt8; w_f0 = w_rs8;       end
      FMT_J:   begin w_f2 = w_req.imm;                                     end
      default: ;
    endcase
    w_word = '0;
    w_word[OPC_LSB +: FIELD_W] = w_req.opcode;
    w_word[F2_LSB  +: FIELD_W] = w_f2;
    w_word[F1_LSB  +: FIELD_W] = w_f1;
    w_word[F0_LSB  +: FIELD_W] = w_f0;
  end

  // Ready depends only on registered occupancy, never on the valid/ready inputs.
  assign w_in_ready = (w_count < FULL_C);
  assign w_accept   = io_bus.in_valid & w_in_ready;
  assign w_pop      = io_bus.out_ready & (w_count != '0);

  instr_fifo #(.DEPTH(DEPTH), .W(INSTR_W)) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (w_accept & w_legal),
    .i_pop   (w_pop),
    .i_data  (w_word),
    .o_data  (w_head),
    .o_count (w_count)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_illegal     <= 1'b0;
      r_illegal_cnt <= '0;
    end else begin
      r_illegal <= w_accept & ~w_legal;
      if (w_accept & ~w_legal & (r_illegal_cnt != 8'hFF))
        r_illegal_cnt <= r_illegal_cnt + 8'd1;
    end
  end

  assign io_bus.in_ready        = w_in_ready;
  assign io_bus.out_valid       = (w_count != '0);
  assign io_bus.out_instruction = w_head;
  assign io_bus.illegal         = r_illegal;
  assign io_bus.illegal_count   = r_illegal_cnt;
  assign io_bus.count           = w_count;
endmodule
